// File: rtl/cache_bus_pkg.sv
// Shared types for the cache bus responder: bus operations, snoop results,
// responder FSM states and the line-alignment mask helper.
package cache_bus_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_INVAL = 2'd2,
    OP_RWIM  = 2'd3
  } bus_op_t;

  typedef enum logic [1:0] {
    SNP_NOHIT = 2'd0,
    SNP_HIT   = 2'd1,
    SNP_HITM  = 2'd2,
    SNP_RSVD  = 2'd3
  } snoop_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SNOOP   = 3'd1,
    ST_COLLECT = 3'd2,
    ST_WAIT_WB = 3'd3,
    ST_MEM     = 3'd4,
    ST_RESP    = 3'd5
  } resp_state_t;

  localparam int unsigned LINE_MASK_W = 64;

  // Clears the byte-select bits; callers truncate to their address width (<= 64).
  function automatic logic [LINE_MASK_W-1:0] line_mask(input int unsigned d_size);
    return {LINE_MASK_W{1'b1}} << d_size;
  endfunction

endpackage

// File: rtl/bus_responder_if.sv
// Request / snoop / completion signal bundle between the last-level cache,
// its peers and the bus responder.
interface bus_responder_if #(
  parameter int i_size  = 32,
  parameter int N_PEERS = 3
);

  logic                   req_valid;
  logic                   req_ready;
  logic [1:0]             req_op;
  logic [i_size-1:0]      req_addr;
  logic                   snp_valid;
  logic [1:0]             snp_op;
  logic [i_size-1:0]      snp_addr;
  logic [2*N_PEERS-1:0]   snp_result;
  logic [N_PEERS-1:0]     snp_result_valid;
  logic                   wb_valid;
  logic                   rsp_valid;
  logic                   rsp_shared;
  logic                   rsp_hitm;
  logic                   proto_err;

  modport master (
    output req_valid, req_op, req_addr, snp_result, snp_result_valid, wb_valid,
    input  req_ready, snp_valid, snp_op, snp_addr, rsp_valid, rsp_shared,
           rsp_hitm, proto_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, snp_result, snp_result_valid, wb_valid,
    output req_ready, snp_valid, snp_op, snp_addr, rsp_valid, rsp_shared,
           rsp_hitm, proto_err
  );

endinterface

// File: rtl/snoop_collector.sv
// Per-peer sticky capture of snoop results; summary flags include strobes
// arriving in the current cycle so the FSM can leave COLLECT without delay.
module snoop_collector
  import cache_bus_pkg::*;
#(
  parameter int N_PEERS = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 en,
  input  logic [2*N_PEERS-1:0] result,
  input  logic [N_PEERS-1:0]   result_valid,
  output logic                 all_rcvd,
  output logic                 any_hit,
  output logic                 any_hitm,
  output logic                 rsvd_seen
);

  logic [N_PEERS-1:0] vld_q, vld_d;
  logic [N_PEERS-1:0] hit_q, hit_d;
  logic [N_PEERS-1:0] hitm_q, hitm_d;
  logic [N_PEERS-1:0] take;
  logic [N_PEERS-1:0] rsvd;
  logic [N_PEERS-1:0] hit_now;
  logic [N_PEERS-1:0] hitm_now;

  generate
    for (genvar gi = 0; gi < N_PEERS; gi++) begin : g_peer
      snoop_t code;
      assign code = snoop_t'(result[2*gi +: 2]);

      // Only the first strobe per peer is captured; a reserved code counts as NOHIT.
      assign take[gi]     = en & result_valid[gi] & ~vld_q[gi];
      assign rsvd[gi]     = en & result_valid[gi] & (code == SNP_RSVD);
      assign hit_now[gi]  = take[gi] & ((code == SNP_HIT) | (code == SNP_HITM));
      assign hitm_now[gi] = take[gi] & (code == SNP_HITM);

      assign vld_d[gi]  = clear ? 1'b0 : (vld_q[gi]  | take[gi]);
      assign hit_d[gi]  = clear ? 1'b0 : (hit_q[gi]  | hit_now[gi]);
      assign hitm_d[gi] = clear ? 1'b0 : (hitm_q[gi] | hitm_now[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= '0;
      hit_q  <= '0;
      hitm_q <= '0;
    end else begin
      vld_q  <= vld_d;
      hit_q  <= hit_d;
      hitm_q <= hitm_d;
    end
  end

  assign all_rcvd  = &(vld_q | take);
  assign any_hit   = |(hit_q | hit_now);
  assign any_hitm  = |(hitm_q | hitm_now);
  assign rsvd_seen = |rsvd;

endmodule

// File: rtl/bus_responder.sv
// Shared-bus responder: snoop broadcast, result collection, dirty writeback
// wait, memory latency and completion. BUS_RESP_STATS_EN adds op counters.
module bus_responder
  import cache_bus_pkg::*;
#(
  parameter int i_size  = 32,
  parameter int d_size  = 6,
  parameter int N_PEERS = 3,
  parameter int MEM_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
`ifdef BUS_RESP_STATS_EN
  output logic [31:0] stat_ops,
  output logic [31:0] stat_hitm,
  output logic [31:0] stat_shared,
  output logic [31:0] stat_inval,
`endif
  bus_responder_if.slave bus
);

  localparam logic [i_size-1:0] LINE_MASK = i_size'(line_mask(d_size));
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  resp_state_t       state_q, state_d;
  bus_op_t           op_q, op_d;
  logic [i_size-1:0] addr_q, addr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              snp_valid_q, snp_valid_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_shared_q, rsp_shared_d;
  logic              rsp_hitm_q, rsp_hitm_d;
  logic              proto_err_q, proto_err_d;

  logic accept;
  logic col_en;
  logic all_rcvd;
  logic any_hit;
  logic any_hitm;
  logic rsvd_seen;

  assign accept = (state_q == ST_IDLE) && bus.req_valid && req_ready_q;
  assign col_en = (state_q == ST_SNOOP) || (state_q == ST_COLLECT);

  snoop_collector #(
    .N_PEERS (N_PEERS)
  ) u_collector (
    .clk          (clk),
    .reset        (reset),
    .clear        (accept),
    .en           (col_en),
    .result       (bus.snp_result),
    .result_valid (bus.snp_result_valid),
    .all_rcvd     (all_rcvd),
    .any_hit      (any_hit),
    .any_hitm     (any_hitm),
    .rsvd_seen    (rsvd_seen)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = bus_op_t'(bus.req_op);
          addr_d  = bus.req_addr & LINE_MASK;
          state_d = ST_SNOOP;
        end
      end
      ST_SNOOP: state_d = ST_COLLECT;
      ST_COLLECT: begin
        if (all_rcvd) begin
          if (any_hitm) begin
            state_d = ST_WAIT_WB;
          end else if (op_q == OP_INVAL) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_MEM;
            cnt_d   = CW'(MEM_LAT - 1);
          end
        end
      end
      ST_WAIT_WB: begin
        if (bus.wb_valid) begin
          if (op_q == OP_INVAL) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_MEM;
            cnt_d   = CW'(MEM_LAT - 1);
          end
        end
      end
      ST_MEM: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    req_ready_d  = (state_d == ST_IDLE);
    snp_valid_d  = (state_d == ST_SNOOP);
    rsp_valid_d  = (state_d == ST_RESP);
    rsp_hitm_d   = rsp_valid_d && any_hitm;
    rsp_shared_d = rsp_valid_d && (op_q == OP_READ) && any_hit;
    proto_err_d  = proto_err_q | rsvd_seen | (~col_en & (|bus.snp_result_valid));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_READ;
      addr_q       <= '0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      snp_valid_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_shared_q <= 1'b0;
      rsp_hitm_q   <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      snp_valid_q  <= snp_valid_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_shared_q <= rsp_shared_d;
      rsp_hitm_q   <= rsp_hitm_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.snp_valid  = snp_valid_q;
  assign bus.snp_op     = op_q;
  assign bus.snp_addr   = addr_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_shared = rsp_shared_q;
  assign bus.rsp_hitm   = rsp_hitm_q;
  assign bus.proto_err  = proto_err_q;

`ifdef BUS_RESP_STATS_EN
  logic [31:0] ops_q, hitm_q, shared_q, inval_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ops_q    <= '0;
      hitm_q   <= '0;
      shared_q <= '0;
      inval_q  <= '0;
    end else if (state_q == ST_RESP) begin
      ops_q <= ops_q + 32'd1;
      if (rsp_hitm_q)        hitm_q   <= hitm_q + 32'd1;
      if (rsp_shared_q)      shared_q <= shared_q + 32'd1;
      if (op_q == OP_INVAL)  inval_q  <= inval_q + 32'd1;
    end
  end

  assign stat_ops    = ops_q;
  assign stat_hitm   = hitm_q;
  assign stat_shared = shared_q;
  assign stat_inval  = inval_q;
`endif

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: cycle-exact latency, sharing/HITM flags,
// protocol error stickiness and reset behaviour.
module tb_bus_responder;
  import cache_bus_pkg::*;

  localparam int NP = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bus_responder_if #(.i_size(32), .N_PEERS(NP)) bus ();

`ifdef BUS_RESP_STATS_EN
  logic [31:0] stat_ops, stat_hitm, stat_shared, stat_inval;
`endif

  bus_responder #(
    .i_size  (32),
    .d_size  (6),
    .N_PEERS (NP),
    .MEM_LAT (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef BUS_RESP_STATS_EN
    .stat_ops    (stat_ops),
    .stat_hitm   (stat_hitm),
    .stat_shared (stat_shared),
    .stat_inval  (stat_inval),
`endif
    .bus         (bus)
  );

  // Strobe schedule, offsets relative to the accept cycle N (-1 = never).
  int         strb_at[NP];
  logic [1:0] strb_code[NP];
  int         wb_at;
  logic       hold_req;

  int          r_n, r_snp, r_snp_cnt, r_rsp;
  logic        r_sh, r_hm, r_busy_ready;
  logic [31:0] r_snp_addr;
  logic [1:0]  r_snp_op;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_rel(input int rel);
    for (int p = 0; p < NP; p++) begin
      bus.snp_result_valid[p] = (strb_at[p] == rel);
      bus.snp_result[2*p +: 2] = (strb_at[p] == rel) ? strb_code[p] : 2'b00;
    end
    bus.wb_valid = (wb_at == rel);
  endtask

  task automatic sched(input int a0, input logic [1:0] c0, input int a1, input logic [1:0] c1,
                       input int a2, input logic [1:0] c2, input int wb);
    strb_at[0] = a0; strb_code[0] = c0;
    strb_at[1] = a1; strb_code[1] = c1;
    strb_at[2] = a2; strb_code[2] = c2;
    wb_at = wb;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] addr);
    int w;
    r_snp = -1; r_rsp = -1; r_snp_cnt = 0; r_sh = 0; r_hm = 0; r_busy_ready = 0;
    w = 0;
    while (bus.req_ready !== 1'b1 && w < 20) begin step(); w++; end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL accept_wait: req_ready=%b required 1", bus.req_ready);
    end
    r_n = cyc;
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = addr;
    for (int rel = 1; rel <= 40 && r_rsp < 0; rel++) begin
      step();
      if (!hold_req) bus.req_valid = 1'b0;
      drive_rel(cyc - r_n);
      if (bus.req_ready === 1'b1) r_busy_ready = 1'b1;
      if (bus.snp_valid === 1'b1) begin
        r_snp_cnt++;
        if (r_snp < 0) begin r_snp = cyc - r_n; r_snp_addr = bus.snp_addr; r_snp_op = bus.snp_op; end
      end
      if (bus.rsp_valid === 1'b1) begin
        r_rsp = cyc - r_n; r_sh = bus.rsp_shared; r_hm = bus.rsp_hitm;
      end
    end
    checks++;
    if (r_rsp < 0) begin errors++; $display("FAIL rsp_timeout: no rsp_valid within 40 cycles, required one"); end
    $display("op=%0d addr=%h N=%0d snp@+%0d rsp@+%0d shared=%b hitm=%b", op, addr, r_n, r_snp, r_rsp, r_sh, r_hm);
  endtask

  task automatic test_reset();
    bus.req_valid = 0; bus.req_op = 0; bus.req_addr = 0;
    bus.snp_result = 0; bus.snp_result_valid = 0; bus.wb_valid = 0;
    hold_req = 0;
    sched(-1, 0, -1, 0, -1, 0, -1);
    reset = 1'b1;
    repeat (3) step();
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b want 0", bus.req_ready); end
    checks++; if (bus.snp_valid !== 1'b0) begin errors++; $display("FAIL rst_snp_valid: got %b want 0", bus.snp_valid); end
    checks++; if (bus.snp_op !== 2'd0) begin errors++; $display("FAIL rst_snp_op: got %0d want 0", bus.snp_op); end
    checks++; if (bus.snp_addr !== 32'h0) begin errors++; $display("FAIL rst_snp_addr: got %h want 0", bus.snp_addr); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); end
    checks++; if ({bus.rsp_shared, bus.rsp_hitm} !== 2'b00) begin errors++; $display("FAIL rst_rsp_flags: got %b want 00", {bus.rsp_shared, bus.rsp_hitm}); end
    checks++; if (bus.proto_err !== 1'b0) begin errors++; $display("FAIL rst_proto_err: got %b want 0", bus.proto_err); end
    reset = 1'b0;
    step();
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b want 1", bus.req_ready); end
    $display("reset: req_ready=%b after release", bus.req_ready);
  endtask

  task automatic test_read_nohit();
    sched(2, SNP_NOHIT, 2, SNP_NOHIT, 2, SNP_NOHIT, -1);
    run_op(OP_READ, 32'h0000_1234);
    checks++; if (r_snp !== 1) begin errors++; $display("FAIL read_snp_cycle: got +%0d want +1", r_snp); end
    checks++; if (r_snp_cnt !== 1) begin errors++; $display("FAIL read_snp_width: got %0d want 1", r_snp_cnt); end
    checks++; if (r_snp_addr !== 32'h0000_1200) begin errors++; $display("FAIL read_snp_addr: got %h want 00001200", r_snp_addr); end
    checks++; if (r_snp_op !== 2'd0) begin errors++; $display("FAIL read_snp_op: got %0d want 0", r_snp_op); end
    checks++; if (r_rsp !== 7) begin errors++; $display("FAIL read_rsp_cycle: got +%0d want +7", r_rsp); end
    checks++; if ({r_sh, r_hm} !== 2'b00) begin errors++; $display("FAIL read_rsp_flags: got %b want 00", {r_sh, r_hm}); end
    checks++; if (r_busy_ready !== 1'b0) begin errors++; $display("FAIL read_busy_ready: got %b want 0", r_busy_ready); end
    step();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL read_rsp_pulse: got %b want 0", bus.rsp_valid); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL read_ready_again: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_read_hit_staggered();
    sched(2, SNP_NOHIT, 4, SNP_HIT, 5, SNP_NOHIT, -1);
    run_op(OP_READ, 32'h0000_4080);
    checks++; if (r_rsp !== 10) begin errors++; $display("FAIL hit_rsp_cycle: got +%0d want +10", r_rsp); end
    checks++; if ({r_sh, r_hm} !== 2'b10) begin errors++; $display("FAIL hit_rsp_flags: got %b want 10", {r_sh, r_hm}); end
    step();
  endtask

  task automatic test_rwim_hitm();
    sched(2, SNP_NOHIT, 2, SNP_NOHIT, 2, SNP_HITM, 9);
    run_op(OP_RWIM, 32'h0000_8040);
    checks++; if (r_snp_op !== 2'd3) begin errors++; $display("FAIL rwim_snp_op: got %0d want 3", r_snp_op); end
    checks++; if (r_rsp !== 14) begin errors++; $display("FAIL rwim_rsp_cycle: got +%0d want +14", r_rsp); end
    checks++; if ({r_sh, r_hm} !== 2'b01) begin errors++; $display("FAIL rwim_rsp_flags: got %b want 01", {r_sh, r_hm}); end
    step();
  endtask

  task automatic test_back_to_back_inval();
    sched(2, SNP_NOHIT, 2, SNP_NOHIT, 2, SNP_NOHIT, -1);
    hold_req = 1'b1;
    run_op(OP_INVAL, 32'h00ab_cdef);
    hold_req = 1'b0;
    checks++; if (r_rsp !== 3) begin errors++; $display("FAIL inval_rsp_cycle: got +%0d want +3", r_rsp); end
    checks++; if ({r_sh, r_hm} !== 2'b00) begin errors++; $display("FAIL inval_rsp_flags: got %b want 00", {r_sh, r_hm}); end
    // Second INVALIDATE is accepted at N+4, so its results are due at N+6.
    sched(6, SNP_NOHIT, 6, SNP_NOHIT, 6, SNP_NOHIT, -1);
    step(); drive_rel(cyc - r_n);
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_n4: got %b want 1", bus.req_ready); end
    step(); bus.req_valid = 1'b0; drive_rel(cyc - r_n);
    checks++; if (bus.snp_valid !== 1'b1) begin errors++; $display("FAIL b2b_snp_n5: got %b want 1", bus.snp_valid); end
    checks++; if (bus.snp_addr !== 32'h00ab_cdc0) begin errors++; $display("FAIL b2b_snp_addr: got %h want 00abcdc0", bus.snp_addr); end
    step(); drive_rel(cyc - r_n);
    step(); drive_rel(cyc - r_n);
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_rsp_n7: got %b want 1", bus.rsp_valid); end
    $display("b2b inval: second rsp at +%0d rsp_valid=%b", cyc - r_n, bus.rsp_valid);
    step(); drive_rel(-1000);
  endtask

  task automatic test_reserved_code();
    checks++; if (bus.proto_err !== 1'b0) begin errors++; $display("FAIL rsvd_err_before: got %b want 0", bus.proto_err); end
    sched(2, SNP_RSVD, 2, SNP_NOHIT, 2, SNP_NOHIT, -1);
    run_op(OP_READ, 32'h0000_0100);
    checks++; if (r_rsp !== 7) begin errors++; $display("FAIL rsvd_rsp_cycle: got +%0d want +7", r_rsp); end
    checks++; if ({r_sh, r_hm} !== 2'b00) begin errors++; $display("FAIL rsvd_rsp_flags: got %b want 00", {r_sh, r_hm}); end
    checks++; if (bus.proto_err !== 1'b1) begin errors++; $display("FAIL rsvd_err_set: got %b want 1", bus.proto_err); end
    step();
    sched(2, SNP_NOHIT, 3, SNP_NOHIT, 2, SNP_NOHIT, -1);
    run_op(OP_WRITE, 32'h0000_0200);
    checks++; if (r_rsp !== 8) begin errors++; $display("FAIL write_rsp_cycle: got +%0d want +8", r_rsp); end
    checks++; if (bus.proto_err !== 1'b1) begin errors++; $display("FAIL rsvd_err_sticky: got %b want 1", bus.proto_err); end
    step();
`ifdef BUS_RESP_STATS_EN
    checks++; if (stat_ops !== 32'd7) begin errors++; $display("FAIL stat_ops: got %0d want 7", stat_ops); end
    checks++; if (stat_hitm !== 32'd1) begin errors++; $display("FAIL stat_hitm: got %0d want 1", stat_hitm); end
    checks++; if (stat_shared !== 32'd1) begin errors++; $display("FAIL stat_shared: got %0d want 1", stat_shared); end
    checks++; if (stat_inval !== 32'd2) begin errors++; $display("FAIL stat_inval: got %0d want 2", stat_inval); end
`endif
  endtask

  task automatic test_reset_mid_mem();
    int w;
    int seen;
    sched(2, SNP_NOHIT, 2, SNP_NOHIT, 2, SNP_NOHIT, -1);
    w = 0;
    while (bus.req_ready !== 1'b1 && w < 20) begin step(); w++; end
    r_n = cyc;
    bus.req_valid = 1'b1; bus.req_op = OP_READ; bus.req_addr = 32'h0000_3000;
    for (int rel = 1; rel <= 4; rel++) begin
      step(); bus.req_valid = 1'b0; drive_rel(cyc - r_n);
    end
    reset = 1'b1; drive_rel(-1000);
    step();
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL mrst_req_ready: got %b want 0", bus.req_ready); end
    checks++; if ({bus.snp_valid, bus.rsp_valid, bus.rsp_shared, bus.rsp_hitm} !== 4'b0000) begin
      errors++; $display("FAIL mrst_outputs: got %b want 0000", {bus.snp_valid, bus.rsp_valid, bus.rsp_shared, bus.rsp_hitm}); end
    checks++; if (bus.snp_addr !== 32'h0) begin errors++; $display("FAIL mrst_snp_addr: got %h want 0", bus.snp_addr); end
    checks++; if (bus.proto_err !== 1'b0) begin errors++; $display("FAIL mrst_proto_err: got %b want 0", bus.proto_err); end
    step();
    reset = 1'b0;
    step();
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL mrst_ready_after: got %b want 1", bus.req_ready); end
    seen = 0;
    for (int i = 0; i < 10; i++) begin step(); if (bus.rsp_valid !== 1'b0) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mrst_no_rsp: got %0d rsp cycles want 0", seen); end
`ifdef BUS_RESP_STATS_EN
    checks++; if ({stat_ops, stat_hitm, stat_shared, stat_inval} !== 128'h0) begin
      errors++; $display("FAIL mrst_stats: got %0d/%0d/%0d/%0d want 0", stat_ops, stat_hitm, stat_shared, stat_inval); end
`endif
    $display("mid-MEM reset: req_ready=%b rsp cycles after=%0d", bus.req_ready, seen);
  endtask

  task automatic test_stray_strobe();
    checks++; if (bus.proto_err !== 1'b0) begin errors++; $display("FAIL stray_err_before: got %b want 0", bus.proto_err); end
    bus.snp_result_valid = 3'b010;
    step();
    bus.snp_result_valid = 3'b000;
    step();
    checks++; if (bus.proto_err !== 1'b1) begin errors++; $display("FAIL stray_err_set: got %b want 1", bus.proto_err); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL stray_still_idle: got %b want 1", bus.req_ready); end
    $display("stray strobe in IDLE: proto_err=%b", bus.proto_err);
  endtask

  initial begin
    test_reset();
    test_read_nohit();
    test_read_hit_staggered();
    test_rwim_hitm();
    test_back_to_back_inval();
    test_reserved_code();
    test_reset_mid_mem();
    test_stray_strobe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
